// File: rtl/regfile_wb_sched.sv
// Write-back arbiter and RAW scoreboard for the 32x32 register file's single write port.
// Define WB_FIXED_PRIO_EN for fixed priority (0 > 1 > 2) instead of round-robin arbitration.
module regfile_wb_sched #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0]   wAddr,
    output logic [DATA_W-1:0]   wDin,
    output logic                wEna,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_dst,
    output logic                iss_ready,
    input  logic [ADDR_W-1:0]   chk_addr1,
    input  logic [ADDR_W-1:0]   chk_addr2,
    output logic                hazard
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [ADDR_W-1:0] w_addr_arr [3];
    logic [DATA_W-1:0] w_data_arr [3];
    logic              w_any;
    logic [1:0]        w_gidx;
    logic              w_inc;

    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdin;
    logic              r_wena;
    logic [1:0]        r_cnt   [NREG];
    logic [1:0]        w_cnt_d [NREG];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_addr_arr[k] = req_addr[ADDR_W*k +: ADDR_W];
            w_data_arr[k] = req_data[DATA_W*k +: DATA_W];
        end
    end

`ifdef WB_FIXED_PRIO_EN
    always_comb begin
        w_any  = |req_valid;
        w_gidx = 2'd0;
        if (req_valid[0]) begin
            w_gidx = 2'd0;
        end else if (req_valid[1]) begin
            w_gidx = 2'd1;
        end else if (req_valid[2]) begin
            w_gidx = 2'd2;
        end
    end
`else
    logic [1:0] r_ptr;
    logic [2:0] w_pos;

    // Scan from lowest priority up so the highest-priority valid requester wins last.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = 2'd0;
        w_pos  = 3'd0;
        for (int off = 2; off >= 0; off--) begin
            w_pos = {1'b0, r_ptr} + 3'(off);
            if (w_pos >= 3'd3) begin
                w_pos = w_pos - 3'd3;
            end
            if (req_valid[w_pos[1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_pos[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
        end else if (w_any) begin
            r_ptr <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
        end
    end
`endif

    assign req_ready = w_any ? (3'b001 << w_gidx) : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_wdin  <= '0;
            r_wena  <= 1'b0;
        end else if (w_any) begin
            r_waddr <= w_addr_arr[w_gidx];
            r_wdin  <= w_data_arr[w_gidx];
            r_wena  <= (w_addr_arr[w_gidx] != '0);
        end else begin
            r_wena  <= 1'b0;
        end
    end

    assign wAddr = r_waddr;
    assign wDin  = r_wdin;
    assign wEna  = r_wena;

    assign iss_ready = (r_cnt[iss_dst] != 2'd3);
    assign w_inc     = iss_valid && iss_ready && (iss_dst != '0);

    // A write retiring in the same cycle as a new issue to that register cancels out.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_cnt_d[i] = r_cnt[i];
            if (w_inc && (iss_dst == ADDR_W'(i)) && !(r_wena && (r_waddr == ADDR_W'(i)))) begin
                w_cnt_d[i] = r_cnt[i] + 2'd1;
            end else if (r_wena && (r_waddr == ADDR_W'(i))
                         && !(w_inc && (iss_dst == ADDR_W'(i))) && (r_cnt[i] != 2'd0)) begin
                w_cnt_d[i] = r_cnt[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

    assign hazard = ((chk_addr1 != '0) && (r_cnt[chk_addr1] != 2'd0))
                 || ((chk_addr2 != '0) && (r_cnt[chk_addr2] != 2'd0));

endmodule
